// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer for the SLC-3 datapath.
// Holds the PC, selects the next PC (PC+INC, address adder, bus, return-stack pop)
// and keeps a small circular return-address stack with sticky overflow/underflow flags.
// Optional feature macro: PC_SEQ_REDIR_CNT_EN enables the saturating redirect counter;
// without it redir_cnt is tied to zero.
module pc_seq_unit #(
  parameter int WIDTH        = 16,
  parameter int INC          = 1,
  parameter int RSTACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              LD_PC,
  input  logic [1:0]                        PCMUX,
  input  logic                              PUSH_RA,
  input  logic                              CLR_FLAGS,
  input  logic [WIDTH-1:0]                  addr_in,
  input  logic [WIDTH-1:0]                  bus_in,
  output logic [WIDTH-1:0]                  pc_out,
  output logic [$clog2(RSTACK_DEPTH+1)-1:0] rs_count,
  output logic                              rs_full,
  output logic                              rs_empty,
  output logic                              rs_ovf,
  output logic                              rs_unf,
  output logic [15:0]                       redir_cnt
);

  localparam int CW = $clog2(RSTACK_DEPTH + 1);
  localparam int PW = $clog2(RSTACK_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [RSTACK_DEPTH];

  logic [WIDTH-1:0] pcInc;
  logic [PW-1:0]    topIdx;
  logic [PW-1:0]    wptrNext;
  logic             doPush;
  logic             doPop;
  logic             isFull;
  logic             isEmpty;

  assign pcInc    = pc_q + WIDTH'(INC);
  assign isFull   = (count_q == CW'(RSTACK_DEPTH));
  assign isEmpty  = (count_q == '0);
  assign topIdx   = (wptr_q == '0) ? PW'(RSTACK_DEPTH - 1) : wptr_q - PW'(1);
  assign wptrNext = (wptr_q == PW'(RSTACK_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
  assign doPush   = LD_PC && PUSH_RA && ((PCMUX == 2'b01) || (PCMUX == 2'b10));
  assign doPop    = LD_PC && (PCMUX == 2'b11) && !isEmpty;

  // Next-state selection for PC, stack pointer/count and sticky flags (clear first, set wins)
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    ovf_d   = CLR_FLAGS ? 1'b0 : ovf_q;
    unf_d   = CLR_FLAGS ? 1'b0 : unf_q;
    if (LD_PC) begin
      unique case (PCMUX)
        2'b00: pc_d = pcInc;
        2'b01: pc_d = addr_in;
        2'b10: pc_d = bus_in;
        default: begin
          if (!isEmpty) begin
            pc_d    = stack_q[topIdx];
            count_d = count_q - CW'(1);
            wptr_d  = topIdx;
          end else begin
            pc_d  = pcInc;
            unf_d = 1'b1;
          end
        end
      endcase
    end
    if (doPush) begin
      wptr_d = wptrNext;
      if (isFull) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Control registers with synchronous reset; reset discards every stack entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= RESET_VEC;
      count_q <= '0;
      wptr_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage: the return address is the PC+INC seen before this load; a full push overwrites the oldest slot
  always_ff @(posedge Clk) begin
    if (!Reset && doPush) begin
      stack_q[wptr_q] <= pcInc;
    end
  end

`ifdef PC_SEQ_REDIR_CNT_EN
  logic [15:0] redir_q, redir_d;

  // Count every non-sequential load, including underflowing pops, saturating at all-ones
  always_comb begin
    redir_d = redir_q;
    if (LD_PC && (PCMUX != 2'b00) && (redir_q != 16'hFFFF)) begin
      redir_d = redir_q + 16'd1;
    end
  end

  // Redirect counter register, cleared only by reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      redir_q <= '0;
    end else begin
      redir_q <= redir_d;
    end
  end

  assign redir_cnt = redir_q;
`else
  assign redir_cnt = 16'h0000;
`endif

  assign pc_out   = pc_q;
  assign rs_count = count_q;
  assign rs_full  = isFull;
  assign rs_empty = isEmpty;
  assign rs_ovf   = ovf_q;
  assign rs_unf   = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed scenarios plus randomized traffic against a queue-based
// reference model of the PC sequencer and its return-address stack.
module tb_pc_seq_unit;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Reset;
  logic        LD_PC;
  logic [1:0]  PCMUX;
  logic        PUSH_RA;
  logic        CLR_FLAGS;
  logic [15:0] addr_in;
  logic [15:0] bus_in;
  logic [15:0] pc_out;
  logic [2:0]  rs_count;
  logic        rs_full;
  logic        rs_empty;
  logic        rs_ovf;
  logic        rs_unf;
  logic [15:0] redir_cnt;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  logic [15:0] mPc;
  logic [15:0] mStack[$];
  logic        mOvf;
  logic        mUnf;
  int          mRedir;

  pc_seq_unit #(
    .WIDTH(16), .INC(1), .RSTACK_DEPTH(DEPTH), .RESET_VEC(16'h0000)
  ) dut (
    .Clk(Clk), .Reset(Reset), .LD_PC(LD_PC), .PCMUX(PCMUX), .PUSH_RA(PUSH_RA),
    .CLR_FLAGS(CLR_FLAGS), .addr_in(addr_in), .bus_in(bus_in), .pc_out(pc_out),
    .rs_count(rs_count), .rs_full(rs_full), .rs_empty(rs_empty), .rs_ovf(rs_ovf),
    .rs_unf(rs_unf), .redir_cnt(redir_cnt)
  );

  // Free-running clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Compare one observed value against its expectation and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance the reference model by one clock edge
  task automatic modelStep(input logic rst, input logic ld, input logic [1:0] mux,
                           input logic push, input logic clr,
                           input logic [15:0] addr, input logic [15:0] bus);
    logic [15:0] nextSeq;
    if (rst) begin
      mPc = 16'h0000;
      mStack.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
      mRedir = 0;
      return;
    end
    if (clr) begin
      mOvf = 1'b0;
      mUnf = 1'b0;
    end
    if (!ld) return;
    nextSeq = mPc + 16'd1;
    if (mux != 2'b00 && mRedir < 65535) mRedir++;
    if (push && (mux == 2'b01 || mux == 2'b10)) begin
      if (mStack.size() == DEPTH) begin
        void'(mStack.pop_front());
        mOvf = 1'b1;
      end
      mStack.push_back(nextSeq);
    end
    case (mux)
      2'b00: mPc = nextSeq;
      2'b01: mPc = addr;
      2'b10: mPc = bus;
      default: begin
        if (mStack.size() > 0) mPc = mStack.pop_back();
        else begin
          mPc = nextSeq;
          mUnf = 1'b1;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, clock it, update the model and check every output
  task automatic applyStimulus(input logic rst, input logic ld, input logic [1:0] mux,
                               input logic push, input logic clr,
                               input logic [15:0] addr, input logic [15:0] bus);
    int expRedir;
    Reset = rst; LD_PC = ld; PCMUX = mux; PUSH_RA = push; CLR_FLAGS = clr;
    addr_in = addr; bus_in = bus;
    @(posedge Clk);
    modelStep(rst, ld, mux, push, clr, addr, bus);
    #1;
`ifdef PC_SEQ_REDIR_CNT_EN
    expRedir = mRedir;
`else
    expRedir = 0;
`endif
    checkOutput("pc_out",    32'(pc_out),    32'(mPc));
    checkOutput("rs_count",  32'(rs_count),  32'(mStack.size()));
    checkOutput("rs_full",   32'(rs_full),   32'(mStack.size() == DEPTH));
    checkOutput("rs_empty",  32'(rs_empty),  32'(mStack.size() == 0));
    checkOutput("rs_ovf",    32'(rs_ovf),    32'(mOvf));
    checkOutput("rs_unf",    32'(rs_unf),    32'(mUnf));
    checkOutput("redir_cnt", 32'(redir_cnt), 32'(expRedir));
  endtask

  initial begin
    int r;
    logic [1:0] mux;
    Reset = 1'b0; LD_PC = 1'b0; PCMUX = 2'b00; PUSH_RA = 1'b0; CLR_FLAGS = 1'b0;
    addr_in = '0; bus_in = '0;
    mPc = '0; mOvf = 1'b0; mUnf = 1'b0; mRedir = 0;

    // Reset then three sequential loads
    applyStimulus(1, 0, 2'b00, 0, 0, 16'h0, 16'h0);
    checkOutput("reset_pc", 32'(pc_out), 32'h0000);
    checkOutput("reset_empty", 32'(rs_empty), 32'h1);
    repeat (3) applyStimulus(0, 1, 2'b00, 0, 0, 16'h0, 16'h0);
    checkOutput("seq3_pc", 32'(pc_out), 32'h0003);

    // Call from 0x0010 to 0x0200, then return
    applyStimulus(0, 1, 2'b10, 0, 0, 16'h0, 16'h0010);
    applyStimulus(0, 1, 2'b01, 1, 0, 16'h0200, 16'h0);
    checkOutput("call_pc", 32'(pc_out), 32'h0200);
    applyStimulus(0, 1, 2'b11, 0, 0, 16'h0, 16'h0);
    checkOutput("ret_pc", 32'(pc_out), 32'h0011);

    // Wrap at FFFF, underflowing pop, flag clear
    applyStimulus(0, 1, 2'b10, 0, 0, 16'h0, 16'hFFFF);
    applyStimulus(0, 1, 2'b00, 0, 0, 16'h0, 16'h0);
    checkOutput("wrap_pc", 32'(pc_out), 32'h0000);
    applyStimulus(0, 1, 2'b11, 0, 0, 16'h0, 16'h0);
    checkOutput("unf_pc", 32'(pc_out), 32'h0001);
    checkOutput("unf_flag", 32'(rs_unf), 32'h1);
    applyStimulus(0, 0, 2'b00, 0, 1, 16'h0, 16'h0);
    checkOutput("unf_clr", 32'(rs_unf), 32'h0);

    // Overflow: five pushes returning 0x0101..0x0105, then four pops
    applyStimulus(0, 1, 2'b10, 0, 0, 16'h0, 16'h0100);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 2'b01, 1, 0, 16'(16'h0100 + i), 16'h0);
    checkOutput("ovf_flag", 32'(rs_ovf), 32'h1);
    checkOutput("ovf_count", 32'(rs_count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 2'b11, 0, 0, 16'h0, 16'h0);
      checkOutput("ovf_pop", 32'(pc_out), 32'(16'h0105 - i));
    end
    checkOutput("ovf_empty", 32'(rs_empty), 32'h1);

    // Clear and set in the same cycle: set wins
    applyStimulus(0, 1, 2'b11, 0, 1, 16'h0, 16'h0);
    checkOutput("clr_vs_set", 32'(rs_unf), 32'h1);

    // Hold with LD_PC low, then reset with three entries stacked
    applyStimulus(0, 0, 2'b10, 1, 0, 16'h0, 16'hABCD);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2'b10, 1, 0, 16'h0, 16'(16'h3000 + i));
    checkOutput("pre_reset_count", 32'(rs_count), 32'h3);
    applyStimulus(1, 1, 2'b10, 1, 0, 16'h0, 16'h1234);
    checkOutput("mid_reset_count", 32'(rs_count), 32'h0);
    checkOutput("mid_reset_pc", 32'(pc_out), 32'h0000);

    // Three redirects and two sequential loads from reset
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2'b01, 0, 0, 16'(16'h0040 * i), 16'h0);
    repeat (2) applyStimulus(0, 1, 2'b00, 0, 0, 16'h0, 16'h0);
`ifdef PC_SEQ_REDIR_CNT_EN
    checkOutput("redir_3", 32'(redir_cnt), 32'h3);
`else
    checkOutput("redir_off", 32'(redir_cnt), 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      mux = 2'($urandom_range(0, 3));
      applyStimulus(r < 2, r < 75, mux, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), 16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
